// File: rtl/hypercpu_fetch.sv
// hypercpu instruction fetch stage.
// Owns PC advance, the req/ack fetch port and branch redirects.
module hypercpu_fetch #(
  parameter int PC_STEP          = 4,
  parameter bit RESET_STATE_IDLE = 1'b1
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic [31:0] read_pc,
  output logic [31:0] next_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  input  logic        halt,
  output logic        misaligned
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] HAVE  = 2'd3;

  // Only IDLE is a legal reset state.
  localparam logic [1:0] RST_STATE =
    RESET_STATE_IDLE ? IDLE : IDLE;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] fetch_addr;
  logic        reload;
  logic        capture;
  logic        ack_step;

  always_comb begin
    state_nxt = state;
    reload    = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!halt) begin
          state_nxt = FETCH;
          reload    = 1'b1;
        end
      end
      FETCH: begin
        if (mem_ack && branch_en) begin
          reload = 1'b1;
        end else if (mem_ack) begin
          capture   = 1'b1;
          state_nxt = HAVE;
        end else if (branch_en) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_ack) begin
          state_nxt = FETCH;
          reload    = 1'b1;
        end
      end
      HAVE: begin
        if (branch_en || (instr_ready && !halt)) begin
          state_nxt = FETCH;
          reload    = 1'b1;
        end else if (instr_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Branch outranks the step, so the step term excludes it.
  assign ack_step = (state == FETCH) && mem_ack && !branch_en;

  always_comb begin
    next_pc = read_pc;
    unique case (1'b1)
      branch_en: next_pc = {branch_target[31:2], 2'b00};
      ack_step:  next_pc = fetch_addr + 32'(PC_STEP);
      default:   next_pc = read_pc;
    endcase
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state      <= RST_STATE;
      fetch_addr <= '0;
      instr      <= '0;
      misaligned <= 1'b0;
    end else begin
      state <= state_nxt;
      if (reload)
        fetch_addr <= read_pc;
      if (capture)
        instr <= mem_rdata;
      if (branch_en && (branch_target[1:0] != 2'b00))
        misaligned <= 1'b1;
    end
  end

  assign mem_req     = (state == FETCH) || (state == DRAIN);
  assign mem_addr    = fetch_addr;
  assign instr_pc    = fetch_addr;
  assign instr_valid = (state == HAVE);

endmodule

// File: doc/hypercpu_fetch.md
# hypercpu_fetch

Instruction fetch stage for the hypercpu core. It owns program-counter advancement: it reads the current PC from the register file's `read_pc` backdoor and drives the register file's `next_pc` backdoor. It issues word reads on a req/ack memory port and presents each fetched instruction to the decoder through a valid/ready handshake. It also handles branch redirects, including discarding a fetch that is already in flight.

## Interface
Parameters:
- `PC_STEP`, default 4: byte increment applied to the PC after each successful fetch.
- `RESET_STATE_IDLE`, default 1: reserved. Must remain 1; the block always leaves reset in IDLE.

Ports:
- `mclk`  in  1: clock. All state updates on posedge.
- `reset`  in  1: asynchronous, active-low reset.
- `read_pc`  in  32: current PC from the register file.
- `next_pc`  out  32: combinational; the register file captures it on negedge `mclk`.
- `mem_req`  out  1: fetch request.
- `mem_addr`  out  32: fetch byte address, registered.
- `mem_ack`  in  1: read data valid. Stable posedge-to-posedge.
- `mem_rdata`  in  32: instruction word, sampled when `mem_ack`=1.
- `instr`  out  32: held instruction.
- `instr_pc`  out  32: address of `instr`.
- `instr_valid`  out  1: `instr` is available to the decoder.
- `instr_ready`  in  1: decoder accepts `instr`.
- `branch_en`  in  1: redirect request. Stable posedge-to-posedge.
- `branch_target`  in  32: redirect address.
- `halt`  in  1: level; stop issuing new fetches.
- `misaligned`  out  1: sticky; set when `branch_target[1:0]`≠0.

## Operation
- State is held in `fetch_addr`, which drives both `mem_addr` and `instr_pc`.
- States:
  - IDLE: `mem_req`=0. Goes to FETCH when `halt`=0, loading `fetch_addr`←`read_pc`.
  - FETCH: `mem_req`=1; `mem_addr`=`fetch_addr`.
    - `mem_ack`=1 and `branch_en`=0: `instr`←`mem_rdata`, go to HAVE.
    - `mem_ack`=1 and `branch_en`=1: discard the data, go to FETCH, load `fetch_addr`←`read_pc`.
    - `mem_ack`=0 and `branch_en`=1: go to DRAIN.
  - DRAIN: `mem_req`=1 with the old address held. Waits for `mem_ack`, discards the data, then goes to FETCH, reloading `fetch_addr`←`read_pc`. A further `branch_en` in DRAIN only updates `next_pc`.
  - HAVE: `instr_valid`=1.
    - `branch_en`=1: drop the instruction, go to FETCH (reload). Branch wins over `instr_ready`.
    - `instr_ready`=1: go to FETCH (reload) if `halt`=0, else go to IDLE.
- Request rule: once `mem_req` rises it stays high, with `mem_addr` unchanged, until the cycle `mem_ack`=1.
- `next_pc` priority:
  1. `branch_en`: {`branch_target[31:2]`,2'b00}.
  2. FETCH with `mem_ack`: `fetch_addr`+`PC_STEP`, mod 2^32 (wraps 0xFFFFFFFC→0x00000000).
  3. Otherwise: `read_pc` (hold).
- `misaligned` is set on any `branch_en` cycle with nonzero low bits. It is cleared only by reset.
- `instr_valid` is 1 only in HAVE.
- `halt` has no effect on a request already in flight or in DRAIN.

## Timing
- Reset values: state IDLE, `mem_req`=0, `mem_addr`=0, `instr`=0, `instr_pc`=0, `instr_valid`=0, `misaligned`=0. `next_pc`=`read_pc` (0 while the register file is in reset).
- Reset mid-fetch abandons the request immediately. A late `mem_ack` arriving in IDLE is ignored.
- `mem_req` is high from the posedge after IDLE with `halt`=0.
- Zero-wait memory: `instr_valid` rises 1 cycle after `mem_req`, i.e. `mem_ack` in the first FETCH cycle.
- Throughput with `instr_ready` held at 1: one instruction per 2 cycles (FETCH, HAVE).
- PC update: on the negedge inside the ack cycle. The new `read_pc` is visible to the FETCH reload at the next posedge.
- Branch in the same cycle as ack plus handshake: the branch target is fetched next and no instruction is delivered.

## Test plan
- Reset, then release with `halt`=0, zero-wait memory, `instr_ready`=1 → `mem_addr` sequence 0,4,8,C; `instr_pc` matches; `next_pc` captured 4,8,C,10.
- `mem_ack` delayed 3 cycles at address 0x10 → `mem_req` and `mem_addr`=0x10 held for 4 cycles; exactly one `instr_valid` with that data.
- `branch_en` to 0x200 during an outstanding fetch at 0x20, with ack 2 cycles later → DRAIN, data discarded, next `mem_addr`=0x200, no `instr_valid` for 0x20.
- `instr_valid` held with `instr_ready`=0 for 5 cycles, then `branch_en` to 0x40 → instruction dropped, next fetch at 0x40.
- `branch_target`=0x103 → `next_pc`=0x100 and `misaligned`=1, remaining 1 until reset. Also: PC at 0xFFFFFFFC, fetch acked → `next_pc`=0.
- `halt`=1 asserted while in HAVE, then handshake → IDLE with `mem_req`=0. Reset asserted mid-FETCH → all outputs return to 0 asynchronously.
